// File: rtl/timestamp_sequencer.sv
// rtl/timestamp_sequencer.sv - Avalon-MM master sequencing arm/stop/capture/irq accesses to the interval timer
module timestamp_sequencer #(
  parameter int READ_LATENCY = 1,
  parameter int TICK_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm_req,
  input  logic [63:0]       arm_period,
  input  logic              arm_cont,
  input  logic              arm_ie,
  input  logic              stop_req,
  input  logic              cap_req,
  output logic              busy,
  output logic              cap_valid,
  output logic [63:0]       cap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [3:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_IRQ_CLR, S_CLR_WAIT, S_STOP_WR, S_ARM_WR, S_CAP_SNAP, S_CAP_RD, S_CAP_DONE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [1:0]  lat, lat_n;
  logic        arm_pend, stop_pend, cap_pend;
  logic        irq_armed;
  logic        start_irq, start_stop, start_arm, start_cap;
  logic        sample;
  logic [63:0] arm_period_q, seq_period;
  logic        arm_cont_q, arm_ie_q, seq_cont, seq_ie;
  logic [63:0] cap_shadow;

  // A serviced irq stays masked until the line is seen low, so a slow-clearing timer is not double-serviced.
  logic irq_go;
  assign irq_go = timer_irq & irq_armed;

  assign busy = (state != S_IDLE) | arm_pend | stop_pend | cap_pend;

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    lat_n         = lat;
    start_irq     = 1'b0;
    start_stop    = 1'b0;
    start_arm     = 1'b0;
    start_cap     = 1'b0;
    sample        = 1'b0;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 4'h0;
    av_writedata  = 16'h0000;
    case (state)
      S_IDLE: begin
        if (irq_go) begin
          state_n   = S_IRQ_CLR;
          start_irq = 1'b1;
        end else if (stop_pend) begin
          state_n    = S_STOP_WR;
          start_stop = 1'b1;
        end else if (arm_pend) begin
          state_n   = S_ARM_WR;
          idx_n     = 3'd0;
          start_arm = 1'b1;
        end else if (cap_pend) begin
          state_n   = S_CAP_SNAP;
          start_cap = 1'b1;
        end
      end
      S_IRQ_CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        state_n       = S_CLR_WAIT;
      end
      S_CLR_WAIT: state_n = S_IDLE;
      S_STOP_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 4'd1;
        av_writedata  = 16'h0008;
        state_n       = S_IDLE;
      end
      S_ARM_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        case (idx)
          3'd0:    begin av_address = 4'd1; av_writedata = 16'h0008;           end
          3'd1:    begin av_address = 4'd2; av_writedata = seq_period[15:0];  end
          3'd2:    begin av_address = 4'd3; av_writedata = seq_period[31:16]; end
          3'd3:    begin av_address = 4'd4; av_writedata = seq_period[47:32]; end
          3'd4:    begin av_address = 4'd5; av_writedata = seq_period[63:48]; end
          default: begin av_address = 4'd1; av_writedata = {12'b0, 1'b0, 1'b1, seq_cont, seq_ie}; end
        endcase
        if (idx == 3'd5) state_n = S_IDLE;
        else             idx_n   = idx + 3'd1;
      end
      S_CAP_SNAP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 4'd6;
        state_n       = S_CAP_RD;
        idx_n         = 3'd0;
        lat_n         = 2'd0;
      end
      S_CAP_RD: begin
        av_chipselect = 1'b1;
        av_address    = 4'd6 + {1'b0, idx};
        if (lat == 2'(READ_LATENCY)) begin
          sample = 1'b1;
          lat_n  = 2'd0;
          if (idx == 3'd3) state_n = S_CAP_DONE;
          else             idx_n   = idx + 3'd1;
        end else begin
          lat_n = lat + 2'd1;
        end
      end
      S_CAP_DONE: state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= 3'd0;
      lat          <= 2'd0;
      arm_pend     <= 1'b0;
      stop_pend    <= 1'b0;
      cap_pend     <= 1'b0;
      irq_armed    <= 1'b1;
      arm_period_q <= 64'd0;
      arm_cont_q   <= 1'b0;
      arm_ie_q     <= 1'b0;
      seq_period   <= 64'd0;
      seq_cont     <= 1'b0;
      seq_ie       <= 1'b0;
      cap_shadow   <= 64'd0;
      cap_value    <= 64'd0;
      cap_valid    <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      lat       <= lat_n;
      arm_pend  <= arm_req  | (arm_pend  & ~start_arm);
      stop_pend <= stop_req | (stop_pend & ~start_stop);
      cap_pend  <= cap_req  | (cap_pend  & ~start_cap);
      if (!timer_irq)     irq_armed <= 1'b1;
      else if (start_irq) irq_armed <= 1'b0;
      if (arm_req) begin
        arm_period_q <= arm_period;
        arm_cont_q   <= arm_cont;
        arm_ie_q     <= arm_ie;
      end
      // Working copy keeps the in-flight ARM sequence stable against a new arm_req.
      if (start_arm) begin
        seq_period <= arm_period_q;
        seq_cont   <= arm_cont_q;
        seq_ie     <= arm_ie_q;
      end
      if (sample) begin
        case (idx)
          3'd0:    cap_shadow[15:0]  <= av_readdata;
          3'd1:    cap_shadow[31:16] <= av_readdata;
          3'd2:    cap_shadow[47:32] <= av_readdata;
          default: cap_shadow[63:48] <= av_readdata;
        endcase
      end
      cap_valid <= (state == S_CAP_DONE);
      if (state == S_CAP_DONE) cap_value <= cap_shadow;
      tick <= (state == S_IRQ_CLR);
      if (state == S_IRQ_CLR) tick_count <= tick_count + 1'b1;
    end
  end

endmodule
